// File: rtl/perf_counter_sequencer.sv
// Round-robin command sequencer in front of a 4-section Avalon performance counter.
// Define PERF_SEQ_COHERENT_SNAP_EN to re-check the time high word and retry once on a carry.
module perf_counter_sequencer #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [2*NUM_REQ-1:0] req_cmd,
    input  logic [2*NUM_REQ-1:0] req_sec,
    output logic [3:0]           pc_address,
    output logic                 pc_write,
    output logic                 pc_begintransfer,
    output logic [31:0]          pc_writedata,
    input  logic [31:0]          pc_readdata,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [IDW-1:0]       res_id,
    output logic [63:0]          res_time,
    output logic [31:0]          res_events,
    output logic                 busy
);

    localparam logic [1:0]   CmdGo   = 2'd0;
    localparam logic [1:0]   CmdStop = 2'd1;
    localparam logic [1:0]   CmdSnap = 2'd2;
    localparam logic [IDW:0] NumReqW = (IDW+1)'(NUM_REQ);

`ifdef PERF_SEQ_COHERENT_SNAP_EN
    typedef enum logic [2:0] {
        StIdle, StWr, StRd0, StRd1, StRd2, StRd3, StResult, StRdChk
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StWr, StRd0, StRd1, StRd2, StRd3, StResult
    } state_e;
`endif

    state_e               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [1:0]           cmd_q, cmd_d;
    logic [1:0]           sec_q, sec_d;
    logic [63:0]          time_q, time_d;
    logic [31:0]          events_q, events_d;
    logic                 run_q;
`ifdef PERF_SEQ_COHERENT_SNAP_EN
    logic                 retry_q, retry_d;
`endif

    logic [2*NUM_REQ-1:0] rot_valid;
    logic                 gnt_found;
    logic [IDW:0]         gnt_sum;
    logic [IDW-1:0]       gnt_idx, gnt_next;
    logic [1:0]           gnt_cmd, gnt_sec;

    // Rotate requests so index 0 is the pointer, take the first set bit, rotate back.
    always_comb begin
        rot_valid = {req_valid, req_valid} >> ptr_q;
        gnt_found = 1'b0;
        gnt_sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && rot_valid[i]) begin
                gnt_found = 1'b1;
                gnt_sum   = {1'b0, ptr_q} + (IDW+1)'(i);
            end
        end
        if (gnt_sum >= NumReqW) begin
            gnt_sum = gnt_sum - NumReqW;
        end
        gnt_idx  = gnt_sum[IDW-1:0];
        gnt_next = (gnt_sum + 1'b1 >= NumReqW) ? '0 : gnt_sum[IDW-1:0] + 1'b1;
        gnt_cmd  = 2'(req_cmd >> {gnt_idx, 1'b0});
        gnt_sec  = 2'(req_sec >> {gnt_idx, 1'b0});
    end

    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        id_d             = id_q;
        cmd_d            = cmd_q;
        sec_d            = sec_q;
        time_d           = time_q;
        events_d         = events_q;
`ifdef PERF_SEQ_COHERENT_SNAP_EN
        retry_d          = retry_q;
`endif
        req_ready        = '0;
        pc_address       = '0;
        pc_write         = 1'b0;
        pc_begintransfer = 1'b0;
        pc_writedata     = '0;
        res_valid        = 1'b0;
        unique case (state_q)
            StIdle: begin
                // run_q keeps req_ready low until the first edge after reset release
                if (run_q && gnt_found) begin
                    req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx;
                    cmd_d     = gnt_cmd;
                    sec_d     = gnt_sec;
                    id_d      = gnt_idx;
                    ptr_d     = gnt_next;
`ifdef PERF_SEQ_COHERENT_SNAP_EN
                    retry_d   = 1'b0;
`endif
                    state_d   = (gnt_cmd == CmdSnap) ? StRd0 : StWr;
                end
            end
            StWr: begin
                pc_write         = 1'b1;
                pc_begintransfer = 1'b1;
                case (cmd_q)
                    CmdGo:   pc_address = {sec_q, 2'd1};
                    CmdStop: pc_address = {sec_q, 2'd0};
                    default: pc_writedata = 32'd1;
                endcase
                state_d = StIdle;
            end
            StRd0: begin
                pc_address = {sec_q, 2'd0};
                state_d    = StRd1;
            end
            StRd1: begin
                pc_address    = {sec_q, 2'd1};
                time_d[31:0]  = pc_readdata;
                state_d       = StRd2;
            end
            StRd2: begin
                pc_address    = {sec_q, 2'd2};
                time_d[63:32] = pc_readdata;
`ifdef PERF_SEQ_COHERENT_SNAP_EN
                state_d       = StRdChk;
`else
                state_d       = StRd3;
`endif
            end
`ifdef PERF_SEQ_COHERENT_SNAP_EN
            StRdChk: begin
                pc_address = {sec_q, 2'd1};
                events_d   = pc_readdata;
                state_d    = StRd3;
            end
            StRd3: begin
                // A changed high word means the low word carried after it was sampled.
                if ((pc_readdata != time_q[63:32]) && !retry_q) begin
                    retry_d = 1'b1;
                    state_d = StRd0;
                end else begin
                    state_d = StResult;
                end
            end
`else
            StRd3: begin
                events_d = pc_readdata;
                state_d  = StResult;
            end
`endif
            StResult: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            id_q     <= '0;
            cmd_q    <= '0;
            sec_q    <= '0;
            time_q   <= '0;
            events_q <= '0;
            run_q    <= 1'b0;
`ifdef PERF_SEQ_COHERENT_SNAP_EN
            retry_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            cmd_q    <= cmd_d;
            sec_q    <= sec_d;
            time_q   <= time_d;
            events_q <= events_d;
            run_q    <= 1'b1;
`ifdef PERF_SEQ_COHERENT_SNAP_EN
            retry_q  <= retry_d;
`endif
        end
    end

    assign busy       = (state_q != StIdle);
    assign res_id     = id_q;
    assign res_time   = time_q;
    assign res_events = events_q;

endmodule

// File: tb/tb_perf_counter_sequencer.sv
// Scoreboard bench for perf_counter_sequencer with a registered counter-slave model.
// Expected torn/coherent snapshot follows PERF_SEQ_COHERENT_SNAP_EN.
module tb_perf_counter_sequencer;
    localparam int NR  = 4;
    localparam int IDW = 3;

`ifdef PERF_SEQ_COHERENT_SNAP_EN
    localparam logic [63:0] TearTime = 64'h0000_0001_0000_0003;
`else
    localparam logic [63:0] TearTime = 64'h0000_0000_FFFF_FFFF;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [2*NR-1:0] req_cmd;
    logic [2*NR-1:0] req_sec;
    logic [3:0]      pc_address;
    logic            pc_write;
    logic            pc_begintransfer;
    logic [31:0]     pc_writedata;
    logic [31:0]     pc_readdata;
    logic            res_valid;
    logic            res_ready;
    logic [IDW-1:0]  res_id;
    logic [63:0]     res_time;
    logic [31:0]     res_events;
    logic            busy;

    logic [1:0]      t_cmd [NR];
    logic [1:0]      t_sec [NR];

    perf_counter_sequencer #(.NUM_REQ(NR), .IDW(IDW)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_cmd          (req_cmd),
        .req_sec          (req_sec),
        .pc_address       (pc_address),
        .pc_write         (pc_write),
        .pc_begintransfer (pc_begintransfer),
        .pc_writedata     (pc_writedata),
        .pc_readdata      (pc_readdata),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_id           (res_id),
        .res_time         (res_time),
        .res_events       (res_events),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_cmd = '0;
        req_sec = '0;
        for (int i = 0; i < NR; i++) begin
            req_cmd[2*i +: 2] = t_cmd[i];
            req_sec[2*i +: 2] = t_sec[i];
        end
    end

    // Counter slave: readdata is registered; tear_mode scripts a low-word wrap on section 0.
    logic [31:0] mem [16];
    logic        tear_mode;
    int          hi_reads;
    always @(posedge clk) begin
        if (!tear_mode) hi_reads <= 0;
        else if (!pc_write && pc_address == 4'd1) hi_reads <= hi_reads + 1;
        if (tear_mode && pc_address == 4'd1)
            pc_readdata <= (hi_reads == 0) ? 32'd0 : 32'd1;
        else if (tear_mode && pc_address == 4'd0)
            pc_readdata <= (hi_reads < 2) ? 32'hFFFF_FFFF : 32'd3;
        else
            pc_readdata <= mem[pc_address];
    end

    typedef struct packed { logic [3:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic [IDW-1:0] id; logic [63:0] tm; logic [31:0] ev; } res_t;
    wr_t  wq[$];
    res_t rq[$];
    int   total, bad, cyc, last_g, mptr, gk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input int r, input logic [1:0] c, input logic [1:0] s);
        t_cmd[r]     = c;
        t_sec[r]     = s;
        req_valid[r] = 1'b1;
    endtask

    // Reference arbiter: first pending requester from the model pointer, with wrap.
    task automatic observe();
        int k;
        int b;
        logic [NR-1:0] e;
        wr_t  w;
        res_t r;
        cyc++;
        if (!reset_n || req_ready == '0) return;
        k = -1;
        for (int i = 0; i < NR; i++)
            if (k < 0 && req_valid[(mptr + i) % NR]) k = (mptr + i) % NR;
        e = '0;
        if (k >= 0) e[k] = 1'b1;
        chk("grant", 64'(req_ready), 64'(e));
        chk("grant_gap", 64'(cyc - last_g >= 2), 64'd1);
        chk("grant_in_result", 64'(res_valid), 64'd0);
        if (k < 0) return;
        b = 4 * int'(t_sec[k]);
        case (t_cmd[k])
            2'd0: begin w.addr = 4'(b + 1); w.data = 32'd0; wq.push_back(w); end
            2'd1: begin w.addr = 4'(b);     w.data = 32'd0; wq.push_back(w); end
            2'd3: begin w.addr = 4'd0;      w.data = 32'd1; wq.push_back(w); end
            default: begin
                r.id = IDW'(k);
                r.tm = tear_mode ? TearTime : {mem[b + 1], mem[b]};
                r.ev = mem[b + 2];
                rq.push_back(r);
            end
        endcase
        mptr   = (k + 1) % NR;
        last_g = cyc;
        gk     = k;
    endtask

    task automatic monitor();
        wr_t  w;
        res_t r;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                chk("bt_follows_write", 64'(pc_begintransfer), 64'(pc_write));
                if (pc_write) begin
                    chk("write_expected", 64'(wq.size() != 0), 64'd1);
                    if (wq.size() != 0) begin
                        w = wq.pop_front();
                        chk("wr_addr", 64'(pc_address), 64'(w.addr));
                        chk("wr_data", 64'(pc_writedata), 64'(w.data));
                    end
                end else begin
                    chk("idle_wdata", 64'(pc_writedata), 64'd0);
                end
                if (res_valid && res_ready) begin
                    chk("result_expected", 64'(rq.size() != 0), 64'd1);
                    if (rq.size() != 0) begin
                        r = rq.pop_front();
                        chk("res_id", 64'(res_id), 64'(r.id));
                        chk("res_time", res_time, r.tm);
                        chk("res_events", 64'(res_events), 64'(r.ev));
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        gk = -1;
        observe();
        @(posedge clk);
        #1;
        if (gk >= 0) req_valid[gk] = 1'b0;
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((req_valid != '0 || wq.size() != 0 || rq.size() != 0) && n < max) begin
            tick();
            n++;
        end
        chk("drain", 64'(req_valid != '0 || wq.size() != 0 || rq.size() != 0), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        int n;
        reset_n = 1'b0; res_ready = 1'b0; tear_mode = 1'b0; req_valid = '0;
        total = 0; bad = 0; cyc = 0; last_g = -10; mptr = 0; gk = -1;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        for (int i = 0; i < NR; i++) issue(i, 2'd0, 2'($urandom_range(0, 3)));
        fork monitor(); join_none

        repeat (2) begin
            @(negedge clk);
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_address", 64'(pc_address), 64'd0);
            chk("rst_write", 64'(pc_write), 64'd0);
            chk("rst_bt", 64'(pc_begintransfer), 64'd0);
            chk("rst_wdata", 64'(pc_writedata), 64'd0);
            chk("rst_res_valid", 64'(res_valid), 64'd0);
            chk("rst_res_id", 64'(res_id), 64'd0);
            chk("rst_res_time", res_time, 64'd0);
            chk("rst_res_events", 64'(res_events), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
        end
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        res_ready = 1'b1;
        drain(40);

        issue(2, 2'd0, 2'd1);
        drain(20);

        // Global reset and a STOP pending together: granted two cycles apart.
        issue(0, 2'd3, 2'd0);
        issue(1, 2'd1, 2'd3);
        drain(20);

        mem[8] = 32'h1111_1111; mem[9] = 32'h2222_2222; mem[10] = 32'd7;
        res_ready = 1'b0;
        issue(3, 2'd2, 2'd2);
        n = 0;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        chk("snap_valid", 64'(res_valid), 64'd1);
        issue(0, 2'd0, 2'd0);
        repeat (5) begin
            tick();
            chk("hold_valid", 64'(res_valid), 64'd1);
            chk("hold_id", 64'(res_id), 64'd3);
            chk("hold_time", res_time, 64'h2222_2222_1111_1111);
            chk("hold_events", 64'(res_events), 64'd7);
            chk("hold_no_grant", 64'(req_ready), 64'd0);
        end
        res_ready = 1'b1;
        drain(20);

        // Abort a snapshot in RD1 with reset.
        issue(1, 2'd2, 2'd1);
        n = 0;
        while (gk != 1 && n < 10) begin
            tick();
            n++;
        end
        chk("abort_grant", 64'(gk), 64'd1);
        chk("rd0_addr", 64'(pc_address), 64'd4);
        @(posedge clk);
        #1;
        chk("rd1_addr", 64'(pc_address), 64'd5);
        chk("rd1_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_res_valid", 64'(res_valid), 64'd0);
        chk("abort_addr", 64'(pc_address), 64'd0);
        if (rq.size() != 0) void'(rq.pop_back());
        mptr = 0;
        last_g = -10;
        issue(3, 2'd0, 2'd2);
        issue(0, 2'd1, 2'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        drain(20);

        tear_mode = 1'b1;
        mem[2] = $urandom;
        issue(2, 2'd2, 2'd0);
        drain(40);
        tear_mode = 1'b0;

        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        repeat (400) begin
            for (int r = 0; r < NR; r++)
                if (!req_valid[r] && $urandom_range(0, 3) == 0)
                    issue(r, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            res_ready = 1'($urandom_range(0, 1));
            tick();
        end
        res_ready = 1'b1;
        drain(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
